// File: rtl/ysyx_22051013_mem_arbiter_pkg.sv
// Shared definitions for the icache/dcache memory arbiter: FSM state and
// owner encodings, the default starvation limit and fixed icache beat shape.
package ysyx_22051013_mem_arbiter_pkg;

    // Consecutive dcache grants tolerated while the icache is kept waiting.
    localparam int YSYX_22051013_STARVE_MAX = 4;

    // The icache always fetches a full aligned doubleword.
    localparam logic [7:0] YSYX_22051013_IMASK = 8'hff;
    localparam logic [2:0] YSYX_22051013_ISIZE = 3'b011;

    typedef enum logic [1:0] {
        YSYX_22051013_IDLE    = 2'd0,
        YSYX_22051013_GNT_I   = 2'd1,
        YSYX_22051013_GNT_D   = 2'd2,
        YSYX_22051013_RELEASE = 2'd3
    } ysyx_22051013_arb_state_e;

    typedef enum logic [1:0] {
        YSYX_22051013_OWN_NONE = 2'd0,
        YSYX_22051013_OWN_I    = 2'd1,
        YSYX_22051013_OWN_D    = 2'd2
    } ysyx_22051013_owner_e;

    // Starvation counter width: wide enough to hold the limit, never below 3 bits.
    function automatic int ysyx_22051013_cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/ysyx_22051013_mem_arbiter_arb_pick.sv
// Combinational priority select between the icache and dcache requesters.
// The dcache normally wins; a fence.i flush (d_lock) always wins; the icache
// wins once it has watched STARVE_MAX dcache grants go by.
module ysyx_22051013_arb_pick
    import ysyx_22051013_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = YSYX_22051013_STARVE_MAX,
    parameter int CNT_W      = 3
) (
    input  logic                 i_re,
    input  logic                 d_req,
    input  logic                 d_lock,
    input  logic [CNT_W-1:0]     starve_cnt,
    output ysyx_22051013_owner_e owner
);

    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    logic icache_starved;

    assign icache_starved = i_re && (starve_cnt >= STARVE_LIMIT);

    // Pick the next owner: flush first, then dcache unless icache is starved.
    always_comb begin
        owner = YSYX_22051013_OWN_NONE;
        if (d_req && d_lock) begin
            owner = YSYX_22051013_OWN_D;
        end else if (d_req && !icache_starved) begin
            owner = YSYX_22051013_OWN_D;
        end else if (i_re) begin
            owner = YSYX_22051013_OWN_I;
        end
    end

endmodule

// File: rtl/ysyx_22051013_mem_arbiter.sv
// Memory arbiter between the icache and the dcache/device-select path in front
// of the single AXI master. One transfer at a time; every transfer is followed
// by a one-cycle release bubble before the next grant.
module ysyx_22051013_mem_arbiter
    import ysyx_22051013_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = YSYX_22051013_STARVE_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    // icache side
    input  logic        i_re,
    input  logic [63:0] i_addr,
    output logic        i_valid,
    output logic [63:0] i_data,
    // dcache side
    input  logic        d_re,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_mask,
    input  logic [2:0]  d_size,
    input  logic        d_lock,
    output logic        d_valid,
    output logic [63:0] d_data,
    // AXI master side
    output logic        axi_re,
    output logic        axi_we,
    output logic [63:0] axi_addr,
    output logic [63:0] axi_wdata,
    output logic [7:0]  axi_mask,
    output logic [2:0]  axi_size,
    input  logic        axi_valid,
    input  logic [63:0] axi_rdata,
    // current owner
    output logic        gnt_i,
    output logic        gnt_d
);

    localparam int               CNT_W        = ysyx_22051013_cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    ysyx_22051013_arb_state_e state_q, state_d;
    logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
    // Cleared by reset, set on the first edge after it: keeps the first grant
    // off the first rising edge following reset release.
    logic                     ready_q, ready_d;

    logic                     d_req;
    ysyx_22051013_owner_e     pick;

    assign d_req = d_re | d_we;

    ysyx_22051013_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_arb_pick (
        .i_re       (i_re),
        .d_req      (d_req),
        .d_lock     (d_lock),
        .starve_cnt (starve_cnt_q),
        .owner      (pick)
    );

    // State, starvation counter and post-reset guard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= YSYX_22051013_IDLE;
            starve_cnt_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ready_q      <= ready_d;
        end
    end

    // Next state and starvation bookkeeping; arbitration only happens in IDLE.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ready_d      = 1'b1;
        case (state_q)
            YSYX_22051013_IDLE: begin
                if (!i_re) begin
                    starve_cnt_d = '0;
                end
                if (ready_q) begin
                    case (pick)
                        YSYX_22051013_OWN_D: begin
                            state_d = YSYX_22051013_GNT_D;
                            if (i_re && !d_lock && (starve_cnt_q < STARVE_LIMIT)) begin
                                starve_cnt_d = starve_cnt_q + CNT_W'(1);
                            end
                        end
                        YSYX_22051013_OWN_I: begin
                            state_d      = YSYX_22051013_GNT_I;
                            starve_cnt_d = '0;
                        end
                        default: begin
                            state_d = YSYX_22051013_IDLE;
                        end
                    endcase
                end
            end
            YSYX_22051013_GNT_I,
            YSYX_22051013_GNT_D: begin
                if (axi_valid) begin
                    state_d = YSYX_22051013_RELEASE;
                end
            end
            YSYX_22051013_RELEASE: begin
                state_d = YSYX_22051013_IDLE;
            end
            default: begin
                state_d = YSYX_22051013_IDLE;
            end
        endcase
    end

    // Route the owner's request to AXI and the AXI response back to the owner.
    always_comb begin
        axi_re    = 1'b0;
        axi_we    = 1'b0;
        axi_addr  = '0;
        axi_wdata = '0;
        axi_mask  = '0;
        axi_size  = '0;
        i_valid   = 1'b0;
        i_data    = '0;
        d_valid   = 1'b0;
        d_data    = '0;
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        case (state_q)
            YSYX_22051013_GNT_I: begin
                gnt_i    = 1'b1;
                axi_re   = i_re;
                axi_addr = i_addr;
                axi_mask = YSYX_22051013_IMASK;
                axi_size = YSYX_22051013_ISIZE;
                if (axi_valid) begin
                    i_valid = 1'b1;
                    i_data  = axi_rdata;
                end
            end
            YSYX_22051013_GNT_D: begin
                gnt_d     = 1'b1;
                axi_re    = d_re;
                axi_we    = d_we;
                axi_addr  = d_addr;
                axi_wdata = d_wdata;
                axi_mask  = d_mask;
                axi_size  = d_size;
                if (axi_valid) begin
                    d_valid = 1'b1;
                    d_data  = axi_rdata;
                end
            end
            default: begin
                gnt_i = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22051013_mem_arbiter.sv
// Self-checking bench for the icache/dcache memory arbiter.
module tb_ysyx_22051013_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_re;
    logic [63:0] i_addr;
    logic        i_valid;
    logic [63:0] i_data;
    logic        d_re;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_mask;
    logic [2:0]  d_size;
    logic        d_lock;
    logic        d_valid;
    logic [63:0] d_data;
    logic        axi_re;
    logic        axi_we;
    logic [63:0] axi_addr;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_mask;
    logic [2:0]  axi_size;
    logic        axi_valid;
    logic [63:0] axi_rdata;
    logic        gnt_i;
    logic        gnt_d;

    int tests_run    = 0;
    int tests_failed = 0;

    ysyx_22051013_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_re      (i_re),
        .i_addr    (i_addr),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_mask    (d_mask),
        .d_size    (d_size),
        .d_lock    (d_lock),
        .d_valid   (d_valid),
        .d_data    (d_data),
        .axi_re    (axi_re),
        .axi_we    (axi_we),
        .axi_addr  (axi_addr),
        .axi_wdata (axi_wdata),
        .axi_mask  (axi_mask),
        .axi_size  (axi_size),
        .axi_valid (axi_valid),
        .axi_rdata (axi_rdata),
        .gnt_i     (gnt_i),
        .gnt_d     (gnt_d)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_idle();
        i_re = 1'b0; i_addr = '0;
        d_re = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        d_mask = '0; d_size = '0; d_lock = 1'b0;
        axi_valid = 1'b0; axi_rdata = '0;
    endtask

    // Called on the negedge of the first grant cycle; completes the transfer
    // after lat extra cycles and returns on the negedge of the release bubble.
    task automatic finish_txn(input int lat);
        repeat (lat) @(negedge clk);
        axi_valid = 1'b1;
        axi_rdata = {$urandom, $urandom};
        @(negedge clk);
        axi_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive_idle();
        #2 rst_n = 1'b0;
        d_re = 1'b1; d_addr = 64'h100;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({gnt_i, gnt_d, axi_re, axi_we, i_valid, d_valid} !== 6'b0) begin
            tests_failed++; $display("[TB] FAIL reset_outputs: got %b expected 000000", {gnt_i, gnt_d, axi_re, axi_we, i_valid, d_valid});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (gnt_d !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_first_edge: gnt_d=%b expected 0", gnt_d);
        end
        @(negedge clk);
        tests_run++;
        if (gnt_d !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL reset_second_edge: gnt_d=%b expected 1", gnt_d);
        end
        finish_txn(0);
        d_re = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        i_re = 1'b1; i_addr = 64'h8000_0000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) begin
                axi_valid = 1'b1; axi_rdata = 64'h1234; #1;
            end
            tests_run++;
            if (axi_re !== 1'b1 || axi_addr !== 64'h8000_0000 || gnt_i !== 1'b1) begin
                tests_failed++; $display("[TB] FAIL single_read_c%0d: re=%b addr=%h gnt_i=%b expected 1 80000000 1", c, axi_re, axi_addr, gnt_i);
            end
            if (c == 1) begin
                tests_run++;
                if ({axi_we, axi_mask, axi_size, axi_wdata} !== {1'b0, 8'hff, 3'b011, 64'h0}) begin
                    tests_failed++; $display("[TB] FAIL single_read_shape: we=%b mask=%h size=%b wdata=%h expected 0 ff 011 0", axi_we, axi_mask, axi_size, axi_wdata);
                end
            end
            tests_run++;
            if (c == 4 && (i_valid !== 1'b1 || i_data !== 64'h1234)) begin
                tests_failed++; $display("[TB] FAIL single_read_data: valid=%b data=%h expected 1 1234", i_valid, i_data);
            end else if (c != 4 && (i_valid !== 1'b0 || i_data !== 64'h0)) begin
                tests_failed++; $display("[TB] FAIL single_read_early_valid: valid=%b data=%h expected 0 0", i_valid, i_data);
            end
        end
        @(negedge clk);
        axi_valid = 1'b0;
        #1;
        tests_run++;
        if ({gnt_i, gnt_d, axi_re, i_valid} !== 4'b0 || i_data !== 64'h0) begin
            tests_failed++; $display("[TB] FAIL single_read_release: gnt_i=%b axi_re=%b i_valid=%b expected 0 0 0", gnt_i, axi_re, i_valid);
        end
        i_re = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        i_re = 1'b1; i_addr = 64'h8000_0040; d_re = 1'b1; d_addr = 64'h200;
        @(negedge clk);
        tests_run++;
        if ({gnt_i, gnt_d} !== 2'b01 || axi_addr !== 64'h200) begin
            tests_failed++; $display("[TB] FAIL simul_dcache_first: gnt_i/gnt_d=%b%b addr=%h expected 01 200", gnt_i, gnt_d, axi_addr);
        end
        finish_txn(1);
        tests_run++;
        if ({gnt_i, gnt_d, axi_re, axi_we} !== 4'b0) begin
            tests_failed++; $display("[TB] FAIL simul_bubble: got %b expected 0000", {gnt_i, gnt_d, axi_re, axi_we});
        end
        d_re = 1'b0;
        @(negedge clk);
        tests_run++;
        if (gnt_i !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL simul_idle: gnt_i=%b expected 0", gnt_i);
        end
        @(negedge clk);
        tests_run++;
        if (gnt_i !== 1'b1 || axi_addr !== 64'h8000_0040) begin
            tests_failed++; $display("[TB] FAIL simul_icache_next: gnt_i=%b addr=%h expected 1 80000040", gnt_i, axi_addr);
        end
        finish_txn(0);
        i_re = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        i_re = 1'b1; d_re = 1'b1; d_addr = 64'h300; i_addr = 64'h8000_0080;
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                tests_run++;
                if (gnt_d !== 1'b1 || int'(dut.starve_cnt_q) != k) begin
                    tests_failed++; $display("[TB] FAIL starve_r%0d_dgrant%0d: gnt_d=%b cnt=%0d expected 1 %0d", r, k, gnt_d, dut.starve_cnt_q, k);
                end
                finish_txn(0);
                if (r == 1 && k == 4) begin
                    d_re = 1'b0; d_we = 1'b1; d_lock = 1'b1;
                end
                @(negedge clk);
            end
            if (r == 1) begin
                @(negedge clk);
                tests_run++;
                if (gnt_d !== 1'b1 || axi_we !== 1'b1 || int'(dut.starve_cnt_q) != 4) begin
                    tests_failed++; $display("[TB] FAIL starve_lock: gnt_d=%b we=%b cnt=%0d expected 1 1 4", gnt_d, axi_we, dut.starve_cnt_q);
                end
                finish_txn(0);
                d_we = 1'b0; d_lock = 1'b0; d_re = 1'b1;
                @(negedge clk);
            end
            @(negedge clk);
            tests_run++;
            if ({gnt_i, gnt_d} !== 2'b10 || int'(dut.starve_cnt_q) != 0) begin
                tests_failed++; $display("[TB] FAIL starve_r%0d_icache: gnt=%b%b cnt=%0d expected 10 0", r, gnt_i, gnt_d, dut.starve_cnt_q);
            end
            finish_txn(0);
            @(negedge clk);
        end
        i_re = 1'b0; d_re = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_valid();
        axi_valid = 1'b1; axi_rdata = 64'hdead_beef;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if ({i_valid, d_valid, gnt_i, gnt_d} !== 4'b0 || i_data !== 64'h0 || d_data !== 64'h0) begin
                tests_failed++; $display("[TB] FAIL stray_valid: valids=%b%b gnts=%b%b expected 00 00", i_valid, d_valid, gnt_i, gnt_d);
            end
        end
        axi_valid = 1'b0; i_re = 1'b1; i_addr = 64'h8000_0100;
        @(negedge clk);
        tests_run++;
        if (gnt_i !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL stray_then_grant: gnt_i=%b expected 1", gnt_i);
        end
        finish_txn(0);
        i_re = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_request();
        d_re = 1'b1; d_addr = 64'h400;
        @(negedge clk);
        d_re = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (gnt_d !== 1'b1) begin
                tests_failed++; $display("[TB] FAIL drop_hold: gnt_d=%b expected 1", gnt_d);
            end
        end
        axi_valid = 1'b1; axi_rdata = 64'h5555_aaaa_0000_ffff;
        #1;
        tests_run++;
        if (d_valid !== 1'b1 || d_data !== 64'h5555_aaaa_0000_ffff) begin
            tests_failed++; $display("[TB] FAIL drop_data: valid=%b data=%h expected 1 5555aaaa0000ffff", d_valid, d_data);
        end
        @(negedge clk);
        axi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_midreset();
        i_re = 1'b1; i_addr = 64'h8000_0200;
        d_we = 1'b1; d_addr = 64'h500; d_wdata = 64'h0123_4567_89ab_cdef; d_mask = 8'h0f; d_size = 3'd2;
        @(negedge clk);
        tests_run++;
        if (gnt_d !== 1'b1 || axi_we !== 1'b1 || axi_wdata !== 64'h0123_4567_89ab_cdef || axi_mask !== 8'h0f) begin
            tests_failed++; $display("[TB] FAIL midreset_write: gnt_d=%b we=%b wdata=%h mask=%h expected 1 1 0123456789abcdef 0f", gnt_d, axi_we, axi_wdata, axi_mask);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({gnt_i, gnt_d, axi_re, axi_we} !== 4'b0 || axi_addr !== 64'h0 || axi_wdata !== 64'h0
            || axi_mask !== 8'h0 || axi_size !== 3'h0 || int'(dut.starve_cnt_q) != 0) begin
            tests_failed++; $display("[TB] FAIL midreset_clear: gnt=%b%b re/we=%b%b addr=%h cnt=%0d expected 00 00 0 0", gnt_i, gnt_d, axi_re, axi_we, axi_addr, dut.starve_cnt_q);
        end
        axi_valid = 1'b1; axi_rdata = 64'h77;
        #1;
        tests_run++;
        if (d_valid !== 1'b0 || d_data !== 64'h0) begin
            tests_failed++; $display("[TB] FAIL midreset_valid: d_valid=%b d_data=%h expected 0 0", d_valid, d_data);
        end
        i_re = 1'b0; d_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if ({i_valid, d_valid, gnt_i, gnt_d} !== 4'b0) begin
                tests_failed++; $display("[TB] FAIL midreset_late_valid: got %b expected 0000", {i_valid, d_valid, gnt_i, gnt_d});
            end
        end
        axi_valid = 1'b0;
        @(negedge clk);
    endtask

    // Random traffic against a transaction-level model: the icache is never
    // made to wait through more than four unlocked dcache grants in a row.
    task automatic test_random();
        int          waited = 0;
        int          exp_owner;
        int          lat;
        logic        ip, dp, lk, dw;
        logic [63:0] rd;
        logic [140:0] exp_axi;
        for (int n = 0; n < 60; n++) begin
            ip = ($urandom_range(0, 3) != 0);
            dp = ($urandom_range(0, 3) != 0);
            if (!ip && !dp) ip = 1'b1;
            lk = dp && ($urandom_range(0, 5) == 0);
            dw = 1'($urandom_range(0, 1));
            i_re = ip; i_addr = {$urandom, $urandom};
            d_re = dp && !dw; d_we = dp && dw; d_lock = lk;
            d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
            d_mask = 8'($urandom_range(0, 255)); d_size = 3'($urandom_range(0, 7));
            if (n != 0) begin
                @(negedge clk);
                tests_run++;
                if ({gnt_i, gnt_d} !== 2'b00) begin
                    tests_failed++; $display("[TB] FAIL rand_bubble_%0d: gnt=%b%b expected 00", n, gnt_i, gnt_d);
                end
            end
            if (dp && (lk || !ip || waited < 4)) exp_owner = 2;
            else exp_owner = 1;
            if (!ip || exp_owner == 1) waited = 0;
            else if (!lk) waited = (waited < 4) ? waited + 1 : 4;
            if (exp_owner == 1) exp_axi = {1'b1, 1'b0, i_addr, 64'h0, 8'hff, 3'b011};
            else exp_axi = {d_re, d_we, d_addr, d_wdata, d_mask, d_size};
            @(negedge clk);
            tests_run++;
            if (gnt_i !== (exp_owner == 1) || gnt_d !== (exp_owner == 2)) begin
                tests_failed++; $display("[TB] FAIL rand_owner_%0d: gnt=%b%b expected owner %0d", n, gnt_i, gnt_d, exp_owner);
            end
            tests_run++;
            if ({axi_re, axi_we, axi_addr, axi_wdata, axi_mask, axi_size} !== exp_axi) begin
                tests_failed++; $display("[TB] FAIL rand_axi_%0d: got %h expected %h", n, {axi_re, axi_we, axi_addr, axi_wdata, axi_mask, axi_size}, exp_axi);
            end
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                @(negedge clk);
                tests_run++;
                if ({i_valid, d_valid} !== 2'b00 || (gnt_i | gnt_d) !== 1'b1) begin
                    tests_failed++; $display("[TB] FAIL rand_wait_%0d: valids=%b%b gnt=%b%b expected 00 held", n, i_valid, d_valid, gnt_i, gnt_d);
                end
            end
            rd = {$urandom, $urandom};
            axi_valid = 1'b1; axi_rdata = rd;
            #1;
            tests_run++;
            if (i_valid !== (exp_owner == 1) || d_valid !== (exp_owner == 2)
                || i_data !== ((exp_owner == 1) ? rd : 64'h0) || d_data !== ((exp_owner == 2) ? rd : 64'h0)) begin
                tests_failed++; $display("[TB] FAIL rand_resp_%0d: i=%b/%h d=%b/%h expected owner %0d data %h", n, i_valid, i_data, d_valid, d_data, exp_owner, rd);
            end
            @(negedge clk);
            axi_valid = 1'b0;
            #1;
            tests_run++;
            if ({gnt_i, gnt_d, axi_re, axi_we, i_valid, d_valid} !== 6'b0) begin
                tests_failed++; $display("[TB] FAIL rand_release_%0d: got %b expected 000000", n, {gnt_i, gnt_d, axi_re, axi_we, i_valid, d_valid});
            end
        end
        drive_idle();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_stray_valid();
        test_drop_request();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
